// File: rtl/mcu_pkg.sv
// Shared types and default widths for the RAM arbiter slice.
package mcu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between two requesters.
// A tie goes to the requester that is not last_id.
module arb_pick
  import mcu_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last_id,
  output logic    valid,
  output req_id_t id
);

  always_comb begin
    valid = req0 | req1;
    id    = 1'b0;
    if (req0 && req1) id = ~last_id;
    else if (req1)    id = 1'b1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: IDLE -> ACCESS -> DONE.
// RAM_ARB_RR_EN selects round-robin on ties; otherwise requester 0 always wins.
module ram_arbiter
  import mcu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_cs,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t        state_q, state_d;
  req_id_t           owner_q, owner_d;
  logic              we_l_q, we_l_d;
  logic [ADDR_W-1:0] addr_l_q, addr_l_d;
  logic [DATA_W-1:0] wdata_l_q, wdata_l_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic    pick_valid;
  req_id_t pick_id;
  req_id_t last_id;
  logic    arb_slot;

  assign arb_slot = (state_q == IDLE) || (state_q == DONE);

`ifdef RAM_ARB_RR_EN
  req_id_t last_q, last_d;

  // Reset value 1 lets requester 0 win the first tie.
  always_comb begin
    last_d = last_q;
    if (arb_slot && pick_valid) last_d = pick_id;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  assign last_id = last_q;
`else
  assign last_id = 1'b1;
`endif

  arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Next state and request latching
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      IDLE, DONE: begin
        if (pick_valid) begin
          state_d   = ACCESS;
          owner_d   = pick_id;
          we_l_d    = pick_id ? we1    : we0;
          addr_l_d  = pick_id ? addr1  : addr0;
          wdata_l_d = pick_id ? wdata1 : wdata0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_l_q) begin
          if (owner_q) rdata1_d = ram_rdata;
          else         rdata0_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; address and write data are zeroed outside ACCESS
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    ram_cs    = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      ACCESS: begin
        gnt0      = ~owner_q;
        gnt1      = owner_q;
        ram_cs    = 1'b1;
        ram_we    = we_l_q;
        ram_re    = ~we_l_q;
        ram_addr  = addr_l_q;
        ram_wdata = wdata_l_q;
      end
      DONE: begin
        done0 = ~owner_q;
        done1 = owner_q;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter sharing the single-port 256x16 `Ram` between the main `controller` and a port-side DMA requester. It sits between both masters and the `Ram` instance and owns `ram_cs`, `ram_re`, `ram_we`, the address and the write data. Each access is latched, presented to the RAM for one cycle and completed with a one-cycle `done` pulse. Read data is returned on the granted requester's `rdata` port.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM data width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request, level, from controller / DMA.
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `reqN`.
- `addr0` / `addr1`  in  ADDR_W  access address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request latched, RAM access in progress.
- `done0` / `done1`  out  1  one-cycle pulse: access complete; `rdataN` valid for reads.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; holds until that requester's next read completes.
- `ram_cs`, `ram_re`, `ram_we`  out  1  RAM strobes.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  data into RAM.
- `ram_rdata`  in  DATA_W  data from RAM, combinational w.r.t. address and strobes.

## Operation
- FSM states:
  - IDLE: no access.
  - ACCESS: RAM strobes driven.
  - DONE: completion cycle.
- Arbitration is evaluated only in IDLE and DONE, on the current `req0` and `req1`:
  - No request: next state IDLE.
  - A winner: latch its `we`, `addr` and `wdata`, record it as owner, next state ACCESS.
- ACCESS, one cycle:
  - Drive `ram_cs=1`, `ram_we=we_l`, `ram_re=!we_l`, `ram_addr=addr_l`, `ram_wdata=wdata_l`.
  - `gntN` is high for the owner.
  - At the closing edge, read accesses capture `ram_rdata` into the owner's `rdata`.
  - Next state is always DONE.
- DONE, one cycle:
  - `doneN` is high for the owner and all RAM strobes are 0.
  - Arbitrate again, which allows back-to-back accesses.
- Writes never modify `rdataN`.
- Requests are level-sensitive. For a single access, a requester drops `req` no later than its DONE cycle; a `req` still high in DONE is treated as a new request.
- Request fields are sampled only at the arbitration edge and may change freely afterwards.
- Only one requester is ever owner, so `gnt0&gnt1` and `done0&done1` are never both 1.

## Timing
- `req` high in IDLE at edge k:
  - `gnt` during cycle k+1 (ACCESS).
  - `done` and valid `rdata` during cycle k+2.
- Sustained throughput: one access every 2 cycles. Both requesters active alternate under round-robin.
- Reset values:
  - All outputs 0, including `rdata0` and `rdata1`.
  - State IDLE.
  - Round-robin pointer set so requester 0 wins the first tie.
- Reset asserted in ACCESS or DONE:
  - At the next edge, state becomes IDLE and strobes drop.
  - No `done` is issued for the aborted access.
  - `rdata` is cleared.
- A requester's `req` dropping during ACCESS does not cancel the access; `done` still pulses.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, the requester not granted most recently wins.
  - The pointer updates on every grant.
- `RAM_ARB_RR_EN` undefined: fixed priority, requester 0 always wins. The pointer logic is not compiled.
- Single requests are granted identically in both builds.

## Structure
- Shared package `mcu_pkg` holds:
  - `ADDR_W`, `DATA_W` defaults.
  - State typedef `arb_state_t` {IDLE, ACCESS, DONE}.
  - Requester index typedef `req_id_t` (1 bit).
- One sub-module, `arb_pick`: combinational winner selection from `req0`, `req1` and the last-grant pointer.
  - Output: `valid`, `id`.
  - Its round-robin input is tied off when `RAM_ARB_RR_EN` is undefined.

## Test plan
- Reset then `req0` write of 0x1234 to address 0x10:
  - `gnt0` in cycle 1, `ram_we=1` with `ram_addr=0x10`.
  - `done0` in cycle 2.
  - `rdata0` stays 0.
- `req1` read of 0x10 after that write:
  - `ram_re=1` in ACCESS.
  - `done1` two cycles after the request with `rdata1=0x1234`.
  - `rdata0` unchanged.
- Both `req` held high for 8 cycles, with `RAM_ARB_RR_EN` defined:
  - Grants 0,1,0,1, each in a separate ACCESS cycle.
  - Never two grants at once.
- Same stimulus with `RAM_ARB_RR_EN` undefined: every grant goes to requester 0 and `gnt1` never pulses.
- `rst` asserted in an ACCESS cycle:
  - Next cycle all outputs 0, state IDLE, no `done`.
  - A new `req0` after reset completes normally.
